// File: rtl/hist_eq_pkg.sv
// Shared types and helpers for the hist_eq_pp histogram equaliser:
// FSM state encoding, bin-count/reciprocal derivations and saturating add.
package hist_eq_pkg;

    typedef enum logic [2:0] {
        RESET_CLR,
        COLLECT,
        DRAIN,
        WALK,
        COMMIT
    } state_t;

    function automatic int calc_nbins(input int dw);
        return 1 << dw;
    endfunction

    // Fixed-point (FRAC fractional bits) factor mapping a pixel count onto 0..NBINS-1.
    function automatic longint calc_recip(input int dw, input int frac, input longint totolnum);
        return (((longint'(1) << dw) - 1) << frac) / totolnum;
    endfunction

    function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b,
                                            input int width);
        logic [63:0] limit;
        logic [63:0] sum;
        limit = (64'd1 << width) - 64'd1;
        sum   = a + b;
        return (sum > limit) ? limit : sum;
    endfunction

endpackage

// File: rtl/hist_eq_ram.sv
// Simple dual-port RAM: one synchronous write port, one registered read port.
// A read of the address being written returns the old contents.
module hist_eq_ram #(
    parameter int AW    = 8,
    parameter int WIDTH = 21
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [0:(1 << AW)-1];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/hist_eq_pp.sv
// Histogram equaliser with ping-pong LUT: collect a frame histogram, build a CDF LUT
// in blanking, remap the next frame. Optional contrast limiting under HIST_EQ_CLIP_EN.
module hist_eq_pp
    import hist_eq_pkg::*;
#(
    parameter int DW       = 8,
    parameter int BITWIDTH = 21,
    parameter int TOTOLNUM = 1920*1080/4,
    parameter int FRAC     = 16
`ifdef HIST_EQ_CLIP_EN
    ,
    parameter int CLIP     = 2**(BITWIDTH-1)
`endif
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] sink_data,
    input  logic          sink_valid,
    input  logic          sink_eop,
    output logic [DW-1:0] source_data,
    output logic          source_valid,
    output logic          busy,
    output logic          err_blank,
    output logic          lut_ready
);

    localparam int NBINS = calc_nbins(DW);
    localparam int MW    = BITWIDTH + DW + FRAC;
    localparam logic [MW-1:0] RECIP = MW'(calc_recip(DW, FRAC, longint'(TOTOLNUM)));
    localparam logic [MW-1:0] HALF  = MW'(64'd1 << (FRAC-1));

    state_t              state;
    logic [DW:0]         clr_cnt;
    logic [DW:0]         walk_addr;
    logic                walk_v1;
    logic                walk_v2;
    logic [DW-1:0]       walk_a2;
    logic                coll_v1;
    logic [BITWIDTH-1:0] cdf;
    logic                active_bank;

    logic [DW-1:0]       hist_raddr;
    logic [DW-1:0]       hist_raddr_q;
    logic [BITWIDTH-1:0] hist_rdata;
    logic                hist_we;
    logic [DW-1:0]       hist_waddr;
    logic [BITWIDTH-1:0] hist_wdata;
    logic                last_we;
    logic [DW-1:0]       last_waddr;
    logic [BITWIDTH-1:0] last_wdata;
    logic [BITWIDTH-1:0] bin_count;
    logic [BITWIDTH-1:0] bin_contrib;

    logic                lut_we;
    logic [DW:0]         lut_waddr;
    logic [DW:0]         lut_raddr;
    logic [DW-1:0]       lut_wdata;
    logic [DW-1:0]       lut_rdata;
    logic [MW-1:0]       scaled;

    logic                pix_v1;
    logic [DW-1:0]       pix_d1;
    logic                pix_id1;

    hist_eq_ram #(.AW(DW), .WIDTH(BITWIDTH)) u_hist (
        .clk  (clk),
        .we   (hist_we),
        .waddr(hist_waddr),
        .wdata(hist_wdata),
        .raddr(hist_raddr),
        .rdata(hist_rdata)
    );

    hist_eq_ram #(.AW(DW+1), .WIDTH(DW)) u_lut (
        .clk  (clk),
        .we   (lut_we),
        .waddr(lut_waddr),
        .wdata(lut_wdata),
        .raddr(lut_raddr),
        .rdata(lut_rdata)
    );

    // The RAM returns stale data when read and written together, so the
    // previous cycle's write is forwarded onto a matching read.
    always_comb begin
        hist_raddr = (state == WALK) ? walk_addr[DW-1:0] : sink_data;
        bin_count  = (last_we && last_waddr == hist_raddr_q) ? last_wdata : hist_rdata;
    end

`ifdef HIST_EQ_CLIP_EN
    always_comb bin_contrib = (bin_count > BITWIDTH'(CLIP)) ? BITWIDTH'(CLIP) : bin_count;
`else
    always_comb bin_contrib = bin_count;
`endif

    always_comb begin
        hist_we    = 1'b0;
        hist_waddr = hist_raddr_q;
        hist_wdata = '0;
        if (!rst) begin
            if (state == RESET_CLR && !clr_cnt[DW]) begin
                hist_we    = 1'b1;
                hist_waddr = clr_cnt[DW-1:0];
            end else if (walk_v1) begin
                hist_we    = 1'b1;
            end else if (coll_v1) begin
                hist_we    = 1'b1;
                hist_wdata = BITWIDTH'(sat_add(64'(bin_count), 64'd1, BITWIDTH));
            end
        end
    end

    always_comb begin
        scaled    = (MW'(cdf) * RECIP + HALF) >> FRAC;
        lut_wdata = (scaled > MW'(NBINS-1)) ? {DW{1'b1}} : scaled[DW-1:0];
        lut_we    = walk_v2 && !rst;
        lut_waddr = {~active_bank, walk_a2};
        lut_raddr = {active_bank, sink_data};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hist_raddr_q <= '0;
            last_we      <= 1'b0;
            last_waddr   <= '0;
            last_wdata   <= '0;
        end else begin
            hist_raddr_q <= hist_raddr;
            last_we      <= hist_we;
            last_waddr   <= hist_waddr;
            last_wdata   <= hist_wdata;
        end
    end

    // Walk pipeline: read bin, accumulate CDF and clear bin, scale and write LUT.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RESET_CLR;
            busy        <= 1'b0;
            clr_cnt     <= '0;
            walk_addr   <= '0;
            walk_v1     <= 1'b0;
            walk_v2     <= 1'b0;
            walk_a2     <= '0;
            coll_v1     <= 1'b0;
            cdf         <= '0;
            active_bank <= 1'b0;
            lut_ready   <= 1'b0;
            err_blank   <= 1'b0;
        end else begin
            coll_v1 <= 1'b0;
            walk_v1 <= 1'b0;
            walk_v2 <= walk_v1;
            walk_a2 <= hist_raddr_q;
            if (walk_v1) cdf <= BITWIDTH'(sat_add(64'(cdf), 64'(bin_contrib), BITWIDTH));
            if (sink_valid && (state == DRAIN || state == WALK || state == COMMIT))
                err_blank <= 1'b1;
            case (state)
                RESET_CLR: begin
                    if (clr_cnt[DW]) begin
                        state <= COLLECT;
                        busy  <= 1'b0;
                    end else begin
                        clr_cnt <= clr_cnt + 1'b1;
                        busy    <= 1'b1;
                    end
                end
                COLLECT: begin
                    if (sink_valid) coll_v1 <= 1'b1;
                    if (sink_valid && sink_eop) begin
                        state <= DRAIN;
                        busy  <= 1'b1;
                    end
                end
                DRAIN: begin
                    state     <= WALK;
                    walk_addr <= '0;
                end
                WALK: begin
                    if (!walk_addr[DW]) begin
                        walk_v1   <= 1'b1;
                        walk_addr <= walk_addr + 1'b1;
                    end
                    if (walk_v2 && walk_a2 == {DW{1'b1}}) state <= COMMIT;
                end
                COMMIT: begin
                    active_bank <= ~active_bank;
                    lut_ready   <= 1'b1;
                    cdf         <= '0;
                    state       <= COLLECT;
                    busy        <= 1'b0;
                end
                default: state <= RESET_CLR;
            endcase
        end
    end

    // Remap path runs in every state; the identity decision travels with the pixel.
    always_ff @(posedge clk) begin
        if (rst) begin
            pix_v1       <= 1'b0;
            pix_d1       <= '0;
            pix_id1      <= 1'b0;
            source_valid <= 1'b0;
            source_data  <= '0;
        end else begin
            pix_v1       <= sink_valid;
            pix_d1       <= sink_data;
            pix_id1      <= !lut_ready;
            source_valid <= pix_v1;
            source_data  <= pix_id1 ? pix_d1 : lut_rdata;
        end
    end

endmodule
